icache_refill: RTL
==================

Name: icache_refill

Overview:
- Miss-handling writer for the instruction cache.
- When the IF stage requests an address and the cache reports a miss, the block fetches the 4 instruction bytes from the byte-wide memory controller port and assembles them little-endian.
- It then issues a single-cycle fill write (enable, address, instruction) to the cache, and forwards the same instruction to IF in that cycle.
- Sits between IF, the instruction cache fill port and the memory controller arbiter.

Parameters:
MEM_LAT, 1, cycles from an accepted (granted) byte address to its data on mem_din; legal 1..3
ADDR_W, 32, address width

Ports:
clk  input  1  clock
rst  input  1  synchronous active-low reset
rdy  input  1  global ready; low freezes the block
fetch_req  input  1  IF requests instruction at pc
pc  input  ADDR_W  fetch address (word aligned)
hit_icache  input  1  cache lookup result for pc, same cycle
flush  input  1  branch mispredict: abort refill
mem_req  output  1  byte read request to memory controller
mem_addr  output  ADDR_W  byte address of request
mem_gnt  input  1  controller accepts mem_addr this cycle
mem_din  input  8  returned byte
fill_en  output  1  one-cycle cache write strobe
fill_addr  output  ADDR_W  address written to cache
fill_inst  output  32  instruction written to cache
inst_ready  output  1  bypass valid to IF (same cycle as fill_en)
inst_out  output  32  bypass instruction
busy  output  1  refill in progress (state != IDLE)

Behaviour:
- Reset (rst==0 at posedge): state=IDLE, counters=0.
  - All outputs 0: mem_req, mem_addr, fill_en, fill_addr, fill_inst, inst_ready, inst_out, busy.
- rdy==0: no register changes; mem_req forced 0. The memory controller is frozen by the same rdy, so no byte is lost.
- FSM states: IDLE, FETCH, DONE. All transitions require rdy==1.
- IDLE:
  - If fetch_req && !hit_icache && !flush: latch base=pc, issue_cnt=0, rcv_cnt=0, go to FETCH.
  - A hit causes no action.
- FETCH, issue side:
  - mem_req=1 while issue_cnt<4; mem_addr=base+issue_cnt.
  - issue_cnt increments on each cycle with mem_req&&mem_gnt.
- FETCH, receive side:
  - A MEM_LAT-deep valid shift register tracks accepted requests.
  - When a valid bit emerges, store mem_din into buf[8*rcv_cnt +: 8] and increment rcv_cnt.
  - When the 4th byte is stored, go to DONE.
- DONE (one cycle):
  - fill_en=1, inst_ready=1.
  - fill_addr=base; fill_inst=inst_out={b3,b2,b1,b0}.
  - Next state is IDLE.
  - fill_en, fill_addr, fill_inst, inst_ready and inst_out are registered outputs. Outside DONE, fill_en and inst_ready are 0; the data outputs hold their last values.
- Latency: with continuous grant, fill_en is asserted 5+MEM_LAT cycles after the miss-detect cycle. For MEM_LAT=1 that is 6.
  - Each cycle of mem_gnt low adds one cycle.
- pc changes during FETCH are ignored (base is latched). IF must hold pc or flush.
- flush in FETCH or DONE:
  - Next state is IDLE; no fill_en; counters and the valid pipeline are cleared.
  - In-flight bytes returning afterwards are discarded.
  - flush takes priority over DONE's fill and over a simultaneous new miss in IDLE.
- In the cycle after DONE, the cache hits, so IF does not re-trigger a miss.
- Reset mid-FETCH aborts immediately: no fill is issued and mem_req is 0 in the next cycle.
- Address arithmetic wraps modulo 2^ADDR_W.

Optional Feature:
- Macro ICACHE_REFILL_PERF_EN.
- When defined, two output ports are added:
  - miss_cnt[31:0]: increments on each fill_en.
  - abort_cnt[31:0]: increments on each flush that aborts a refill in FETCH/DONE.
  - Both are 0 on reset, saturate at 0xFFFFFFFF, and do not change when rdy==0.
- When undefined, the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Miss, continuous grant, MEM_LAT=1. Setup: pc=0x1000, hit=0, bytes 0x13,0x05,0x10,0x00 at 0x1000..0x1003.
  - mem_addr sequence 0x1000..0x1003.
  - fill_en high exactly 6 cycles after the miss cycle, with fill_addr=0x1000, fill_inst=inst_out=0x00100513.
- Hit: fetch_req=1, hit_icache=1 for 10 cycles -> mem_req stays 0, busy stays 0.
- Grant stalls: mem_gnt low on the 2nd issue for 3 cycles -> fill delayed by 3 cycles, data still 0x00100513.
- Flush after 2 bytes returned -> no fill_en; busy drops the next cycle.
  - A late byte arriving afterwards is ignored.
  - A new miss at 0x2000 then fills correctly.
- rdy low for 4 cycles mid-FETCH -> mem_req=0 and all registers held; fill is delayed by 4 cycles with correct data.
- With ICACHE_REFILL_PERF_EN, MEM_LAT=3: 3 completed misses and 1 flushed refill -> miss_cnt=3, abort_cnt=1. Reset mid-FETCH -> both counters 0, no fill.

Source files
------------

// File: rtl/icache_refill_if.sv
// rtl/icache_refill_if.sv - memory-controller and cache-fill signal bundle for icache_refill
interface icache_refill_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt;
    logic [7:0]        mem_din;
    logic              fill_en;
    logic [ADDR_W-1:0] fill_addr;
    logic [31:0]       fill_inst;

    modport master (
        output mem_req, mem_addr, fill_en, fill_addr, fill_inst,
        input  mem_gnt, mem_din
    );

    modport slave (
        input  mem_req, mem_addr, fill_en, fill_addr, fill_inst,
        output mem_gnt, mem_din
    );
endinterface

// File: rtl/icache_refill.sv
// rtl/icache_refill.sv - icache miss refill: 4 byte reads, little-endian assembly, one-cycle fill + IF bypass
// Optional ICACHE_REFILL_PERF_EN adds saturating miss_cnt/abort_cnt outputs.
module icache_refill #(
    parameter int MEM_LAT = 1,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] pc,
    input  logic              hit_icache,
    input  logic              flush,
    icache_refill_if.master   bus,
    output logic              inst_ready,
    output logic [31:0]       inst_out,
    output logic              busy
`ifdef ICACHE_REFILL_PERF_EN
    ,
    output logic [31:0]       miss_cnt,
    output logic [31:0]       abort_cnt
`endif
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]         state;
    logic [ADDR_W-1:0]  base;
    logic [2:0]         issue_cnt;
    logic [1:0]         rcv_cnt;
    logic [MEM_LAT-1:0] vpipe;
    logic [23:0]        data_buf;
    logic [ADDR_W-1:0]  fill_addr_q;
    logic [31:0]        fill_inst_q;

    logic req, accept, byte_in, fill_fire, abort;

    assign req       = rdy && (state == FETCH) && !issue_cnt[2];
    assign accept    = req && bus.mem_gnt;
    assign byte_in   = (state == FETCH) && vpipe[MEM_LAT-1];
    assign abort     = rdy && flush && (state != IDLE);
    // A flush in the DONE cycle suppresses the strobe even though state is already DONE.
    assign fill_fire = (state == DONE) && !(rdy && flush);

    assign bus.mem_req   = req;
    assign bus.mem_addr  = base + ADDR_W'(issue_cnt);
    assign bus.fill_en   = fill_fire;
    assign bus.fill_addr = fill_addr_q;
    assign bus.fill_inst = fill_inst_q;
    assign inst_ready    = fill_fire;
    assign inst_out      = fill_inst_q;
    assign busy          = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            base        <= '0;
            issue_cnt   <= '0;
            rcv_cnt     <= '0;
            vpipe       <= '0;
            data_buf    <= '0;
            fill_addr_q <= '0;
            fill_inst_q <= '0;
        end else if (rdy) begin
            if (flush || state != FETCH)
                vpipe <= '0;
            else
                vpipe <= MEM_LAT'({vpipe, accept});

            case (state)
                IDLE: begin
                    if (fetch_req && !hit_icache && !flush) begin
                        base      <= pc;
                        issue_cnt <= '0;
                        rcv_cnt   <= '0;
                        state     <= FETCH;
                    end
                end
                FETCH: begin
                    if (flush) begin
                        state     <= IDLE;
                        issue_cnt <= '0;
                        rcv_cnt   <= '0;
                    end else begin
                        if (accept)
                            issue_cnt <= issue_cnt + 3'd1;
                        if (byte_in) begin
                            rcv_cnt <= rcv_cnt + 2'd1;
                            case (rcv_cnt)
                                2'd0:    data_buf[7:0]   <= bus.mem_din;
                                2'd1:    data_buf[15:8]  <= bus.mem_din;
                                2'd2:    data_buf[23:16] <= bus.mem_din;
                                default: begin
                                    // Fourth byte goes straight into the output registers.
                                    state       <= DONE;
                                    fill_addr_q <= base;
                                    fill_inst_q <= {bus.mem_din, data_buf};
                                end
                            endcase
                        end
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    issue_cnt <= '0;
                    rcv_cnt   <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ICACHE_REFILL_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            miss_cnt  <= '0;
            abort_cnt <= '0;
        end else if (rdy) begin
            if (fill_fire && miss_cnt != 32'hFFFF_FFFF)
                miss_cnt <= miss_cnt + 32'd1;
            if (abort && abort_cnt != 32'hFFFF_FFFF)
                abort_cnt <= abort_cnt + 32'd1;
        end
    end
`endif
endmodule
